alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// Instruction sequencer for an external ALU: decode, 8-entry register file, IDLE/EXEC/WB FSM.
// Define ALU_CTRL_ERR_EN to flag ops 3'b110/3'b111 as illegal (err pulse, no writeback).
module alu_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [15:0]                  instr,
    output logic [2:0]                   alu_opcode,
    output logic signed [DATA_WIDTH-1:0] alu_in1,
    output logic signed [DATA_WIDTH-1:0] alu_in2,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic                         alu_z,
    output logic                         wb_valid,
    output logic [2:0]                   wb_rd,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         z_out,
    output logic                         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // imm6[5:3] doubles as rt when imm_sel is 0.
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        logic       imm_sel;
        logic [5:0] imm6;
    } instr_t;

    state_t                state;
    state_t                state_next;
    instr_t                ir;
    logic                  accept;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] regs [1:7];
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;
    logic [DATA_WIDTH-1:0] imm_ext;

    assign accept  = instr_valid && instr_ready;
    assign imm_ext = {{(DATA_WIDTH-6){ir.imm6[5]}}, ir.imm6};

`ifdef ALU_CTRL_ERR_EN
    assign illegal = (ir.op[2:1] == 2'b11);
`else
    assign illegal = 1'b0;
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        instr_ready = 1'b0;
        alu_opcode  = '0;
        alu_in1     = '0;
        alu_in2     = '0;
        wb_valid    = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: instr_ready = !rst;
            EXEC: begin
                alu_opcode = ir.op;
                alu_in1    = rs_val;
                alu_in2    = ir.imm_sel ? imm_ext : rt_val;
            end
            WB: begin
                instr_ready = !rst;
                wb_valid    = !rst && !illegal;
                err         = !rst && illegal;
            end
            default: ;
        endcase
    end

    // Operands are read in EXEC, so a WB write at the accept edge is already visible.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (ir.rs != 3'd0) rs_val = regs[ir.rs];
        if (ir.imm6[5:3] != 3'd0) rt_val = regs[ir.imm6[5:3]];
    end

    // Instruction register is pure datapath and is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            ir <= instr;
        end
    end

    // Writeback registers capture the ALU at the end of EXEC and hold until the next legal op.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_rd   <= '0;
            wb_data <= '0;
            z_out   <= 1'b0;
        end else if (state == EXEC && !illegal) begin
            wb_rd   <= ir.rd;
            wb_data <= alu_result;
            z_out   <= alu_z;
        end
    end

    // Register file; r0 has no storage and writes to it vanish.
    // NOTE: the register file is reset explicitly because r1..r7 must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (state == WB && !illegal && wb_rd != 3'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

endmodule
